// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared counter type, counter encodings and FSM states for the branch predictor
package bp_pkg;
    typedef logic [1:0] bp_cnt_t;
    localparam bp_cnt_t STRONG_NT = 2'b00;
    localparam bp_cnt_t WEAK_NT   = 2'b01;
    localparam bp_cnt_t WEAK_T    = 2'b10;
    localparam bp_cnt_t STRONG_T  = 2'b11;
    typedef enum logic {BP_INIT, BP_RUN} bp_state_e;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: combinational 2-bit saturating counter next-state function
module sat_counter2
    import bp_pkg::*;
(
    input  bp_cnt_t cnt,
    input  logic    taken,
    output bp_cnt_t cnt_next
);
    assign cnt_next = taken ? ((cnt == STRONG_T) ? STRONG_T : cnt + 2'd1)
                            : ((cnt == STRONG_NT) ? STRONG_NT : cnt - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: self-initialising bimodal predictor; BP_GSHARE_EN adds gshare history indexing
module branch_predictor
    import bp_pkg::*;
#(
    parameter int      ENTRIES  = 64,
    parameter bp_cnt_t CNT_INIT = WEAK_NT,
    parameter int      GHR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred_taken,
    output logic        mispredict
);
    localparam int IDX_BITS = $clog2(ENTRIES);

    bp_state_e           r_state;
    bp_state_e           w_state_next;
    logic [IDX_BITS-1:0] r_init_idx;
    bp_cnt_t             r_table [ENTRIES];
    logic [IDX_BITS-1:0] w_pred_idx;
    logic [IDX_BITS-1:0] w_upd_idx;
    bp_cnt_t             w_upd_next;
    logic                w_upd_en;
    logic                w_unused;

    assign w_unused = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0], upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;
    logic [IDX_BITS-1:0] w_ghr_ext;

    assign w_ghr_ext  = IDX_BITS'(r_ghr);
    assign w_pred_idx = pred_pc[IDX_BITS+1:2] ^ w_ghr_ext;
    assign w_upd_idx  = upd_pc[IDX_BITS+1:2] ^ w_ghr_ext;

    // history shifts only on accepted updates, so the update index above sees the pre-shift value
    always_ff @(posedge clk) begin
        if (rst) r_ghr <= '0;
        else if (w_upd_en) r_ghr <= {r_ghr[GHR_BITS-2:0], upd_taken};
    end
`else
    logic w_unused_ghr;

    assign w_unused_ghr = GHR_BITS[0];
    assign w_pred_idx   = pred_pc[IDX_BITS+1:2];
    assign w_upd_idx    = upd_pc[IDX_BITS+1:2];
`endif

    assign ready      = (r_state == BP_RUN);
    assign w_upd_en   = ready & upd_valid;
    assign pred_taken = ready & r_table[w_pred_idx][1];
    assign mispredict = w_upd_en & (upd_taken != upd_pred_taken);

    sat_counter2 u_sat (
        .cnt      (r_table[w_upd_idx]),
        .taken    (upd_taken),
        .cnt_next (w_upd_next)
    );

    // FSM state and init sweep pointer; reset restarts the sweep
    always_ff @(posedge clk) begin
        r_state    <= rst ? BP_INIT : w_state_next;
        r_init_idx <= rst ? '0 : ((r_state == BP_INIT) ? r_init_idx + 1'b1 : r_init_idx);
    end

    // leave INIT once the last entry is being written
    always_comb begin
        w_state_next = (r_state == BP_INIT && r_init_idx == IDX_BITS'(ENTRIES - 1)) ? BP_RUN : r_state;
    end

    // table writes: init sweep or training; the reset edge leaves contents alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == BP_INIT) r_table[r_init_idx] <= CNT_INIT;
            else if (w_upd_en) r_table[w_upd_idx] <= w_upd_next;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed checks of branch_predictor against a behavioural model
module tb_branch_predictor;
    localparam int ENT  = 64;
    localparam int IDXB = 6;
    localparam int GHRB = 6;

    logic        clk = 0;
    logic        rst = 1;
    logic        ready;
    logic [31:0] pred_pc = 32'h100;
    logic        pred_taken;
    logic        upd_valid = 0;
    logic [31:0] upd_pc = 32'h100;
    logic        upd_taken = 0;
    logic        upd_pred_taken = 0;
    logic        mispredict;

    int checks = 0;
    int failures = 0;

    int m_tab [ENT];
    bit m_ready = 0;
    int m_init_cnt = 0;
    int m_ghr = 0;

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .ready          (ready),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict)
    );

    always #5 clk = ~clk;

    function automatic int midx(logic [31:0] pc);
        int i;
        i = int'(pc[IDXB+1:2]);
`ifdef BP_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic bit exp_pred();
        return m_ready && (m_tab[midx(pred_pc)] >= 2);
    endfunction

    function automatic bit exp_misp();
        return m_ready && upd_valid && (upd_taken != upd_pred_taken);
    endfunction

    function automatic void model_edge();
        int k;
        if (rst) begin
            m_ready = 0;
            m_init_cnt = 0;
            m_ghr = 0;
        end else if (!m_ready) begin
            m_tab[m_init_cnt] = 1;
            m_init_cnt++;
            if (m_init_cnt == ENT) m_ready = 1;
        end else if (upd_valid) begin
            k = midx(upd_pc);
            m_tab[k] = upd_taken ? ((m_tab[k] == 3) ? 3 : m_tab[k] + 1)
                                 : ((m_tab[k] == 0) ? 0 : m_tab[k] - 1);
            m_ghr = ((m_ghr << 1) | int'(upd_taken)) % (1 << GHRB);
        end
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic train(logic [31:0] pc, logic t);
        upd_valid = 1;
        upd_pc = pc;
        upd_taken = t;
        upd_pred_taken = t;
        cycle();
        upd_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        upd_valid = 1;
        upd_taken = 1;
        upd_pred_taken = 0;
        for (int c = 0; c < 3; c++) cycle();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++;
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", pred_taken); end
        checks++;
        if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_misp got=%b exp=0", mispredict); end
        upd_valid = 0;
    endtask

    task automatic test_init();
        int edges;
        rst = 0;
        pred_pc = 32'h100;
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin
            checks++;
            if (pred_taken !== 1'b0) begin failures++; $display("FAIL init_pred edge=%0d got=%b exp=0", edges, pred_taken); end
            if (edges == 10) begin
                upd_valid = 1;
                upd_pc = 32'h100;
                upd_taken = 1;
                upd_pred_taken = 0;
                checks++;
                if (mispredict !== 1'b0) begin failures++; $display("FAIL init_misp got=%b exp=0", mispredict); end
            end
            cycle();
            upd_valid = 0;
            edges++;
        end
        checks++;
        if (edges != ENT) begin failures++; $display("FAIL init_len got=%0d exp=%0d", edges, ENT); end
        checks++;
        if (pred_taken !== exp_pred()) begin failures++; $display("FAIL init_after_pred got=%b exp=%b", pred_taken, exp_pred()); end
    endtask

    task automatic test_saturation();
        logic seq [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};
        pred_pc = 32'h100;
        for (int s = 0; s < 9; s++) begin
            train(32'h100, seq[s]);
            checks++;
            if (pred_taken !== exp_pred()) begin failures++; $display("FAIL sat step=%0d got=%b exp=%b", s, pred_taken, exp_pred()); end
        end
    endtask

    task automatic test_aliasing();
        train(32'h100, 1);
        train(32'h100, 1);
        pred_pc = 32'h200;
        #1;
        checks++;
        if (pred_taken !== exp_pred()) begin failures++; $display("FAIL alias_200 got=%b exp=%b", pred_taken, exp_pred()); end
        pred_pc = 32'h104;
        #1;
        checks++;
        if (pred_taken !== exp_pred()) begin failures++; $display("FAIL alias_104 got=%b exp=%b", pred_taken, exp_pred()); end
    endtask

    task automatic test_mispredict();
        logic [2:0] vec [3] = '{3'b110, 3'b111, 3'b010};
        logic       want [3] = '{1, 0, 0};
        for (int v = 0; v < 3; v++) begin
            {upd_valid, upd_taken, upd_pred_taken} = vec[v];
            upd_pc = 32'h300;
            #1;
            checks++;
            if (mispredict !== want[v]) begin failures++; $display("FAIL misp v=%0d got=%b exp=%b", v, mispredict, want[v]); end
            cycle();
        end
        upd_valid = 0;
    endtask

    task automatic test_reset_midrun();
        int edges;
        for (int t = 0; t < 3; t++) train(32'h100, 1);
        pred_pc = 32'h100;
        rst = 1;
        cycle();
        rst = 0;
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin
            cycle();
            edges++;
        end
        checks++;
        if (edges != ENT) begin failures++; $display("FAIL midrun_len got=%0d exp=%0d", edges, ENT); end
        checks++;
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL midrun_pred got=%b exp=0", pred_taken); end
    endtask

    task automatic test_collision();
        pred_pc = 32'h100;
        upd_pc = 32'h100;
        upd_valid = 1;
        upd_taken = 1;
        upd_pred_taken = 0;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL coll_same got=%b exp=0", pred_taken); end
        cycle();
        upd_valid = 0;
        checks++;
        if (pred_taken !== exp_pred()) begin failures++; $display("FAIL coll_next got=%b exp=%b", pred_taken, exp_pred()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            pred_pc = {22'($urandom), 2'($urandom_range(0, 3)), 8'($urandom)} & 32'h0000_03ff;
            upd_valid = $urandom_range(0, 1);
            upd_pc = (upd_valid && $urandom_range(0, 1)) ? pred_pc : (32'($urandom) & 32'h0000_03ff);
            upd_taken = $urandom_range(0, 1);
            upd_pred_taken = $urandom_range(0, 1);
            #1;
            checks++;
            if (ready !== m_ready || pred_taken !== exp_pred() || mispredict !== exp_misp()) begin
                failures++;
                $display("FAIL rand n=%0d ready=%b/%b pred=%b/%b misp=%b/%b", n, ready, m_ready, pred_taken, exp_pred(), mispredict, exp_misp());
            end
            cycle();
        end
        rst = 0;
        upd_valid = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_init();
        test_saturation();
        test_aliasing();
        test_mispredict();
        test_reset_midrun();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
